// File: rtl/pkt_fifo_if.sv
// Handshake and status bundle between the packet receive logic (master)
// and the packet FIFO (slave).
interface pkt_fifo_if #(
  parameter int pDATA_WIDTH = 8,
  parameter int pDEPTH      = 16
);
  localparam int CW = $clog2(pDEPTH) + 1;

  logic                   iwr;
  logic [pDATA_WIDTH-1:0] iw_data;
  logic                   iw_eop;
  logic                   iw_drop;
  logic                   ird;
  logic [pDATA_WIDTH-1:0] or_data;
  logic                   or_eop;
  logic                   oempty;
  logic                   ofull;
  logic                   oafull;
  logic [CW-1:0]          ocount;
  logic                   oovf;
  logic                   opkt_err;

  modport master (
    output iwr, iw_data, iw_eop, iw_drop, ird,
    input  or_data, or_eop, oempty, ofull, oafull, ocount, oovf, opkt_err
  );

  modport slave (
    input  iwr, iw_data, iw_eop, iw_drop, ird,
    output or_data, or_eop, oempty, ofull, oafull, ocount, oovf, opkt_err
  );
endinterface

// File: rtl/pkt_fifo.sv
// Single-clock packet FIFO with packet commit/discard: words become readable
// only once their packet's eop word has been written without overflow.
module pkt_fifo #(
  parameter int pDATA_WIDTH   = 8,
  parameter int pDEPTH        = 16,
  parameter int pAFULL_THRESH = pDEPTH - 4
) (
  input  logic     iclk,
  input  logic     ireset_n,
  pkt_fifo_if.slave bus
);
  localparam int AW = $clog2(pDEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE     = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(pDEPTH);
  localparam logic [PW-1:0] AFULL_P = PW'(pAFULL_THRESH);

  typedef logic [PW-1:0] ptr_t;

  logic [pDATA_WIDTH:0] r_mem [pDEPTH];

  ptr_t r_wr_ptr;
  ptr_t r_cm_ptr;
  ptr_t r_rd_ptr;
  logic r_err;
  logic r_ovf;
  logic r_pkt_err;

  ptr_t w_wr_ptr_nxt;
  ptr_t w_cm_ptr_nxt;
  ptr_t w_rd_ptr_nxt;
  logic w_err_nxt;
  logic w_ovf_nxt;
  logic w_pkt_err_nxt;
  logic w_wr_en;
  ptr_t w_used;
  logic w_full;
  logic w_empty;
  logic [pDATA_WIDTH:0] w_head;

  // Status is derived only from registered pointers, so it reflects pre-edge state.
  assign w_used  = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_used == DEPTH_P);
  assign w_empty = (r_cm_ptr == r_rd_ptr);

  // Write side: tentative write pointer, commit pointer and overflow tracking.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/else tree can leave a signal unassigned and infer a latch.
    w_wr_ptr_nxt  = r_wr_ptr;
    w_cm_ptr_nxt  = r_cm_ptr;
    w_err_nxt     = r_err;
    w_ovf_nxt     = 1'b0;
    w_pkt_err_nxt = 1'b0;
    w_wr_en       = 1'b0;

    if (bus.iw_drop) begin
      w_wr_ptr_nxt = r_cm_ptr;
      w_err_nxt    = 1'b0;
    end else if (bus.iwr) begin
      if (!w_full) begin
        w_wr_en = 1'b1;
        if (!bus.iw_eop) begin
          w_wr_ptr_nxt = r_wr_ptr + ONE;
        end else if (r_err) begin
          // Packet already lost a word: rewind instead of committing.
          w_wr_ptr_nxt  = r_cm_ptr;
          w_err_nxt     = 1'b0;
          w_pkt_err_nxt = 1'b1;
        end else begin
          w_wr_ptr_nxt = r_wr_ptr + ONE;
          w_cm_ptr_nxt = r_wr_ptr + ONE;
        end
      end else begin
        w_ovf_nxt = 1'b1;
        if (bus.iw_eop) begin
          w_wr_ptr_nxt  = r_cm_ptr;
          w_err_nxt     = 1'b0;
          w_pkt_err_nxt = 1'b1;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
    end
  end

  // Read side is independent of the write side.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    if (bus.ird && !w_empty) begin
      w_rd_ptr_nxt = r_rd_ptr + ONE;
    end
  end

  always_ff @(posedge iclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!ireset_n) begin
      r_wr_ptr  <= '0;
      r_cm_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_pkt_err <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_cm_ptr  <= w_cm_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_err     <= w_err_nxt;
      r_ovf     <= w_ovf_nxt;
      r_pkt_err <= w_pkt_err_nxt;
    end
  end

  // NOTE: the storage array has no reset; pointers alone define which
  // entries are meaningful, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge iclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {bus.iw_eop, bus.iw_data};
    end
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  assign bus.or_data  = w_head[pDATA_WIDTH-1:0];
  assign bus.or_eop   = w_head[pDATA_WIDTH];
  assign bus.oempty   = w_empty;
  assign bus.ofull    = w_full;
  assign bus.oafull   = (w_used >= AFULL_P);
  assign bus.ocount   = r_cm_ptr - r_rd_ptr;
  assign bus.oovf     = r_ovf;
  assign bus.opkt_err = r_pkt_err;
endmodule

// File: tb/tb_pkt_fifo.sv
// Directed bench for pkt_fifo: read data checked by a scoreboard monitor,
// status flags and pulses checked inline against hand-computed values.
module tb_pkt_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pkt_fifo_if #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH)) bus ();

  pkt_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pAFULL_THRESH(AF)) dut (
    .iclk     (clk),
    .ireset_n (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW:0] sb [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read is accepted on the coming edge, so compare the head word now.
  logic [DW:0] exp_word;
  always @(negedge clk) begin
    if (rst_n && bus.ird && !bus.oempty) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h with empty scoreboard", {bus.or_eop, bus.or_data});
      end else begin
        exp_word = sb.pop_front();
        check("rd_word", 32'({bus.or_eop, bus.or_data}), 32'(exp_word));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle(logic wr, logic [DW-1:0] d, logic eop, logic drop, logic rd);
    bus.iwr     = wr;
    bus.iw_data = d;
    bus.iw_eop  = eop;
    bus.iw_drop = drop;
    bus.ird     = rd;
    @(posedge clk);
    #1;
    bus.iwr     = 1'b0;
    bus.iw_data = '0;
    bus.iw_eop  = 1'b0;
    bus.iw_drop = 1'b0;
    bus.ird     = 1'b0;
  endtask

  task automatic put(logic [DW-1:0] d, logic eop);
    cycle(1'b1, d, eop, 1'b0, 1'b0);
  endtask

  task automatic expect_word(logic [DW-1:0] d, logic eop);
    sb.push_back({eop, d});
  endtask

  task automatic rd();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flags(string tag, int e, int f, int a, int c);
    check({tag, "_empty"}, 32'(bus.oempty), 32'(e));
    check({tag, "_full"},  32'(bus.ofull),  32'(f));
    check({tag, "_afull"}, 32'(bus.oafull), 32'(a));
    check({tag, "_count"}, 32'(bus.ocount), 32'(c));
  endtask

  task automatic pulses(string tag, int ovf, int perr);
    check({tag, "_ovf"},     32'(bus.oovf),     32'(ovf));
    check({tag, "_pkt_err"}, 32'(bus.opkt_err), 32'(perr));
  endtask

  initial begin
    bus.iwr = 1'b0; bus.iw_data = '0; bus.iw_eop = 1'b0; bus.iw_drop = 1'b0; bus.ird = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    flags("reset", 1, 0, 0, 0);
    pulses("reset", 0, 0);
    rst_n = 1'b1;

    // 3-word packet becomes visible only after its eop edge.
    put(8'h11, 1'b0);
    flags("t1_w1", 1, 0, 0, 0);
    put(8'h22, 1'b0);
    flags("t1_w2", 1, 0, 0, 0);
    expect_word(8'h11, 1'b0);
    expect_word(8'h22, 1'b0);
    expect_word(8'h33, 1'b1);
    put(8'h33, 1'b1);
    flags("t1_commit", 0, 0, 0, 3);
    rd(); check("t1_cnt2", 32'(bus.ocount), 2);
    rd(); check("t1_cnt1", 32'(bus.ocount), 1);
    rd(); flags("t1_drained", 1, 0, 0, 0);

    // Fill with an uncommitted packet, then overflow on the eop word.
    for (int i = 1; i <= 16; i++) begin
      put(8'(8'h80 + i), 1'b0);
      check($sformatf("t2_afull_%0d", i), 32'(bus.oafull), (i >= 12) ? 1 : 0);
      check($sformatf("t2_full_%0d", i),  32'(bus.ofull),  (i == 16) ? 1 : 0);
      check($sformatf("t2_empty_%0d", i), 32'(bus.oempty), 1);
    end
    pulses("t2_full", 0, 0);
    put(8'hFF, 1'b1);
    pulses("t2_ovf_eop", 1, 1);
    flags("t2_after", 1, 0, 0, 0);
    idle();
    pulses("t2_clear", 0, 0);

    // Drop wins over a same-cycle write; used falls back to the committed 4.
    for (int i = 0; i < 4; i++) begin
      expect_word(8'(8'hA0 + i), (i == 3));
      put(8'(8'hA0 + i), (i == 3));
    end
    put(8'hB0, 1'b0);
    put(8'hB1, 1'b0);
    cycle(1'b1, 8'hBF, 1'b0, 1'b1, 1'b0);
    pulses("t3_drop", 0, 0);
    flags("t3_drop", 0, 0, 0, 4);
    for (int i = 0; i < 7; i++) put(8'(8'hC0 + i), 1'b0);
    check("t3_afull_11", 32'(bus.oafull), 0);
    put(8'hC7, 1'b0);
    check("t3_afull_12", 32'(bus.oafull), 1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    flags("t3_drop2", 0, 0, 0, 4);
    repeat (4) rd();
    flags("t3_drained", 1, 0, 0, 0);

    // Committed 10-word packet survives an overflowing follow-on packet.
    for (int i = 0; i < 10; i++) begin
      expect_word(8'(8'h40 + i), (i == 9));
      put(8'(8'h40 + i), (i == 9));
    end
    flags("t4_commit", 0, 0, 0, 10);
    for (int i = 0; i < 6; i++) put(8'(8'hD0 + i), 1'b0);
    flags("t4_full", 0, 1, 1, 10);
    put(8'hD6, 1'b0);
    pulses("t4_refused", 1, 0);
    check("t4_still_full", 32'(bus.ofull), 1);
    put(8'hD7, 1'b1);
    pulses("t4_eop", 1, 1);
    flags("t4_after", 0, 0, 0, 10);
    repeat (10) rd();
    flags("t4_drained", 1, 0, 0, 0);

    // Wrap-around with one-word packets.
    for (int v = 0; v < 40; v++) begin
      expect_word(8'(v), 1'b1);
      put(8'(v), 1'b1);
      check($sformatf("t5_cnt_w%0d", v), 32'(bus.ocount), 1);
      rd();
      check($sformatf("t5_cnt_r%0d", v), 32'(bus.ocount), 0);
      check($sformatf("t5_empty_%0d", v), 32'(bus.oempty), 1);
    end

    // Reset with committed and open data discards everything.
    for (int i = 0; i < 5; i++) put(8'(8'h50 + i), (i == 4));
    for (int i = 0; i < 3; i++) put(8'(8'h60 + i), 1'b0);
    flags("t6_pre", 0, 0, 0, 5);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    flags("t6_reset", 1, 0, 0, 0);
    pulses("t6_reset", 0, 0);
    expect_word(8'h70, 1'b0);
    expect_word(8'h71, 1'b1);
    put(8'h70, 1'b0);
    put(8'h71, 1'b1);
    flags("t6_commit", 0, 0, 0, 2);
    rd();
    rd();
    flags("t6_drained", 1, 0, 0, 0);

    idle();
    check("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_fifo.md
# pkt_fifo

Parametrised packet FIFO, the next generation of the single-clock register-file FIFO used in the packet copy path. Adds configurable width and depth, occupancy and almost-full outputs, and packet-level commit/discard. Words become visible to the reader only when the packet's last word is written, so a packet that overflows or is dropped upstream never reaches the read side. Sits between the packet receive logic and the packet memory copier.

## Interface

- pDATA_WIDTH, 8, data word width in bits
- pDEPTH, 16, storage depth in words; power of two, ≥ 4
- pAFULL_THRESH, pDEPTH-4, oafull asserts when used slots ≥ this value; range 1..pDEPTH

- iclk  in  1  clock; all logic on rising edge
- ireset_n  in  1  synchronous active-low reset
- iwr  in  1  write request
- iw_data  in  pDATA_WIDTH  write data
- iw_eop  in  1  qualifies iwr: the word is the last of its packet
- iw_drop  in  1  discard the current uncommitted packet
- ird  in  1  read request; pops the word on or_data
- or_data  out  pDATA_WIDTH  head word, first-word fall-through
- or_eop  out  1  stored eop flag of the head word
- oempty  out  1  no committed words
- ofull  out  1  no free slot (committed plus uncommitted words = pDEPTH)
- oafull  out  1  used slots ≥ pAFULL_THRESH
- ocount  out  $clog2(pDEPTH)+1  committed, unread words
- oovf  out  1  one-cycle pulse: write refused because full
- opkt_err  out  1  one-cycle pulse: packet discarded because of overflow

## Operation

- Storage: pDEPTH × (pDATA_WIDTH+1), holding {eop, data}. Array is not reset.
- Three pointers, each $clog2(pDEPTH)+1 bits, with an MSB wrap bit: wr_ptr (tentative write), cm_ptr (commit), rd_ptr (read). All pointer arithmetic is modulo 2^(AW+1).
- used = wr_ptr − rd_ptr; ocount = cm_ptr − rd_ptr.
- ofull = (used == pDEPTH); oempty = (cm_ptr == rd_ptr); oafull = (used ≥ pAFULL_THRESH). All three are derived from registered pointers.
- Write accepted when iwr & ~ofull & ~iw_drop: the word is stored at wr_ptr, and wr_ptr advances by 1.
- iwr & ofull: the word is lost, oovf pulses, and the internal err flag is set for the current packet.
- Accepted write with iw_eop: if err is clear, cm_ptr ← wr_ptr+1. If err is set, wr_ptr ← cm_ptr, err is cleared, and opkt_err pulses.
- Refused write (full) with iw_eop: wr_ptr ← cm_ptr, err is cleared, and both opkt_err and oovf pulse.
- iw_drop: wr_ptr ← cm_ptr and err is cleared. iw_drop takes priority over a same-cycle iwr, which is ignored with no oovf. No opkt_err pulse.
- Read: when ird & ~oempty, rd_ptr advances by 1. ird while empty is ignored, with no state change.
- Simultaneous read and write are independent. Full and empty are evaluated on pre-edge state, so a write at full is refused even if a read occurs in the same cycle.
- or_data and or_eop come combinationally from the array at rd_ptr. They are don't-care while oempty=1.

## Timing

- Reset (ireset_n=0 at an edge): all pointers = 0, err = 0, oempty=1, ofull=0, oafull=0, ocount=0, oovf=0, opkt_err=0. or_data and or_eop are don't-care.
- Reset mid-packet discards all contents, both committed and uncommitted.
- Commit latency: eop written at edge N → oempty falls and or_data is valid after edge N. ocount updates on the same edge.
- A non-eop write changes ofull and oafull after the edge but never changes oempty or ocount.
- A read at edge N → the next head word is on or_data after edge N.
- oovf and opkt_err are high for exactly one cycle per triggering event.
- Wrap-around: pointers roll over at 2^(AW+1) with no discontinuity in ocount, ofull or oempty.

## Test plan

- Reset, then write a 3-word packet (0x11, 0x22, 0x33 with eop on the last): oempty stays 1 until after the eop edge, then ocount=3. Reading 3 words returns 0x11/0x22/0x33 with or_eop=0/0/1, then oempty=1.
- With pDEPTH=16 and pAFULL_THRESH=12, write 16 non-eop words: oafull=1 after the 12th write, ofull=1 after the 16th, and oempty=1 throughout. A 17th write with eop produces oovf=1 and opkt_err=1. Afterwards used=0, ofull=0 and oempty=1.
- Commit a 4-word packet, write 2 words, assert iw_drop together with iwr: no oovf pulse. ocount=4, and used returns to 4. Reading yields only the first packet.
- Commit a 10-word packet, then start a 7-word packet: oovf pulses on the refused word. The eop write then pulses opkt_err. Reads return exactly the 10 words of the first packet.
- Wrap-around: 40 one-word packets with values 0..39, reading each packet one cycle after its commit: all 40 values are read in order and ocount never exceeds 1.
- Assert ireset_n=0 for one cycle while ocount=5 with a 3-word packet open: all outputs return to their reset values and a subsequent packet reads back correctly.
